// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator and output stage.
//
// Sync, blank and the pixel pipeline are generated for the mode set by the
// parameters. Each line and each frame run sync, back porch, active, front
// porch. Pixel coordinates go to a host renderer, and the host colour comes
// back a fixed PIX_LAT cycles later. The block also provides colour-bar,
// border and black modes, plus frame and game ticks.
//
// Ports:
//   iCLK, iRST_N               pixel clock, async active-low reset
//   iRed/iGreen/iBlue [CW]     host colour, valid PIX_LAT cycles after oReq/oCoord
//   iMode [2]                  0 host, 1 colour bars, 2 host + white border, 3 black;
//                              sampled only on oFrameTick
//   oCoord_X/oCoord_Y [CNT_W]  active-area coordinate (holds outside active area)
//   oReq                       coordinate valid
//   oVGA_R/G/B [CW]            registered colour, zero whenever blanked
//   oVGA_H_SYNC, oVGA_V_SYNC   active-low syncs, aligned with the colour
//   oVGA_BLANK                 high during active video
//   oVGA_SYNC                  constant 0
//   oVGA_CLOCK                 iCLK pass-through
//   oFrameTick                 one-cycle pulse at the start of vertical front porch
//   oGameTick                  one-cycle pulse every TICK_DIV frames
//
// Latency: oReq/oCoord for counter position (h,v) is registered once. Sync,
// blank and colour for that position leave the output register PIX_LAT+1
// cycles after oReq/oCoord show it.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACT    = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACT    = 480,
  parameter int V_FRONT  = 10,
  parameter int CW       = 10,
  parameter int CNT_W    = 10,
  parameter int PIX_LAT  = 2,
  parameter int TICK_DIV = 4
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [CW-1:0]    iRed,
  input  logic [CW-1:0]    iGreen,
  input  logic [CW-1:0]    iBlue,
  input  logic [1:0]       iMode,
  output logic [CNT_W-1:0] oCoord_X,
  output logic [CNT_W-1:0] oCoord_Y,
  output logic             oReq,
  output logic [CW-1:0]    oVGA_R,
  output logic [CW-1:0]    oVGA_G,
  output logic [CW-1:0]    oVGA_B,
  output logic             oVGA_H_SYNC,
  output logic             oVGA_V_SYNC,
  output logic             oVGA_BLANK,
  output logic             oVGA_SYNC,
  output logic             oVGA_CLOCK,
  output logic             oFrameTick,
  output logic             oGameTick
);

  localparam int H_TOT = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int V_TOT = V_SYNC + V_BACK + V_ACT + V_FRONT;
  localparam int HA_S  = H_SYNC + H_BACK;
  localparam int HA_E  = HA_S + H_ACT;
  localparam int VA_S  = V_SYNC + V_BACK;
  localparam int VA_E  = VA_S + V_ACT;
  localparam int BAR_W = H_ACT / 8;
  localparam int FC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(TICK_DIV - 1);

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vid;
    logic [1:0] mode;
    logic       border;
    logic [2:0] bar;
  } pix_t;

  logic [CNT_W-1:0] h, v;
  logic [CNT_W-1:0] bar_pix;
  logic [2:0]       bar_idx;
  logic [FC_W-1:0]  fcnt;
  logic [1:0]       mode_q;
  logic             h_act, v_act, active, border, frame_tick;
  pix_t             s0, dly;
  logic [CW-1:0]    r_n, g_n, b_n;
  logic [2:0]       bar_k;

  assign oVGA_SYNC  = 1'b0;
  assign oVGA_CLOCK = iCLK;

  // Position counters
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  assign h_act  = (h >= CNT_W'(HA_S)) && (h < CNT_W'(HA_E));
  assign v_act  = (v >= CNT_W'(VA_S)) && (v < CNT_W'(VA_E));
  assign active = h_act && v_act;
  assign border = (h == CNT_W'(HA_S)) || (h == CNT_W'(HA_E - 1)) ||
                  (v == CNT_W'(VA_S)) || (v == CNT_W'(VA_E - 1));

  assign frame_tick = (h == '0) && (v == CNT_W'(VA_E));
  assign oFrameTick = frame_tick;
  assign oGameTick  = frame_tick && (fcnt == FC_LAST);

  // Frame divider and frame-synchronous mode sample
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      fcnt   <= '0;
      mode_q <= '0;
    end else if (frame_tick) begin
      fcnt   <= (fcnt == FC_LAST) ? '0 : fcnt + 1'b1;
      mode_q <= iMode;
    end
  end

  // Bar counter: during position x these hold x mod BAR_W and x / BAR_W.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (active) begin
      if (bar_pix == BAR_LAST) begin
        bar_pix <= '0;
        bar_idx <= bar_idx + 1'b1;
      end else begin
        bar_pix <= bar_pix + 1'b1;
      end
    end else begin
      bar_pix <= '0;
      bar_idx <= '0;
    end
  end

  // Request stage: coordinates and the attributes that ride alongside them
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s0       <= '0;
      oReq     <= 1'b0;
      oCoord_X <= '0;
      oCoord_Y <= '0;
    end else begin
      s0.hs     <= (h >= CNT_W'(H_SYNC));
      s0.vs     <= (v >= CNT_W'(V_SYNC));
      s0.vid    <= active;
      s0.mode   <= mode_q;
      s0.border <= border;
      s0.bar    <= bar_idx;
      oReq      <= active;
      if (active) begin
        oCoord_X <= h - CNT_W'(HA_S);
        oCoord_Y <= v - CNT_W'(VA_S);
      end
    end
  end

  // Match the host fetch latency
  generate
    if (PIX_LAT == 0) begin : g_nodly
      assign dly = s0;
    end else begin : g_dly
      pix_t line [PIX_LAT];
      always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
          for (int unsigned i = 0; i < PIX_LAT; i++) line[i] <= '0;
        end else begin
          line[0] <= s0;
          for (int unsigned i = 1; i < PIX_LAT; i++) line[i] <= line[i-1];
        end
      end
      assign dly = line[PIX_LAT-1];
    end
  endgenerate

  // Bar i shows k = 7-i as {R,G,B} bits: white first, black last.
  assign bar_k = 3'd7 - dly.bar;

  always_comb begin
    r_n = '0;
    g_n = '0;
    b_n = '0;
    if (dly.vid) begin
      case (dly.mode)
        2'd0: begin
          r_n = iRed;
          g_n = iGreen;
          b_n = iBlue;
        end
        2'd1: begin
          r_n = {CW{bar_k[2]}};
          g_n = {CW{bar_k[1]}};
          b_n = {CW{bar_k[0]}};
        end
        2'd2: begin
          r_n = dly.border ? '1 : iRed;
          g_n = dly.border ? '1 : iGreen;
          b_n = dly.border ? '1 : iBlue;
        end
        default: begin
          r_n = '0;
          g_n = '0;
          b_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oVGA_R      <= '0;
      oVGA_G      <= '0;
      oVGA_B      <= '0;
      oVGA_H_SYNC <= 1'b0;
      oVGA_V_SYNC <= 1'b0;
      oVGA_BLANK  <= 1'b0;
    end else begin
      oVGA_R      <= r_n;
      oVGA_G      <= g_n;
      oVGA_B      <= b_n;
      oVGA_H_SYNC <= dly.hs;
      oVGA_V_SYNC <= dly.vs;
      oVGA_BLANK  <= dly.vid;
    end
  end

endmodule
